// File: rtl/avalon_ram_arbiter.sv
// Three-master Avalon arbiter (dbg > core buses) onto one memory port.
// Optional RAM_ARB_ROUND_ROBIN_EN: dbus/ibus tie broken by round-robin.
module avalon_ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dbg_avn_read,
  input  logic            dbg_avn_write,
  input  logic [AW-1:0]   dbg_avn_address,
  input  logic [DW/8-1:0] dbg_avn_byte_enable,
  input  logic [DW-1:0]   dbg_avn_writedata,
  output logic [DW-1:0]   dbg_avn_readdata,
  output logic            dbg_avn_waitrequest,
  input  logic            dbus_avn_read,
  input  logic            dbus_avn_write,
  input  logic [AW-1:0]   dbus_avn_address,
  input  logic [DW/8-1:0] dbus_avn_byte_enable,
  input  logic [DW-1:0]   dbus_avn_writedata,
  output logic [DW-1:0]   dbus_avn_readdata,
  output logic            dbus_avn_waitrequest,
  input  logic            ibus_avn_read,
  input  logic            ibus_avn_write,
  input  logic [AW-1:0]   ibus_avn_address,
  input  logic [DW/8-1:0] ibus_avn_byte_enable,
  input  logic [DW-1:0]   ibus_avn_writedata,
  output logic [DW-1:0]   ibus_avn_readdata,
  output logic            ibus_avn_waitrequest,
  output logic            ram_avn_read,
  output logic            ram_avn_write,
  output logic [AW-1:0]   ram_avn_address,
  output logic [DW/8-1:0] ram_avn_byte_enable,
  output logic [DW-1:0]   ram_avn_writedata,
  input  logic [DW-1:0]   ram_avn_readdata,
  input  logic            ram_avn_waitrequest
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {
    OWN_NONE, OWN_DBG, OWN_DBUS, OWN_IBUS
  } owner_t;

  state_t state;
  owner_t owner;
  owner_t win;
  owner_t sel;

  logic req_dbg;
  logic req_dbus;
  logic req_ibus;
  logic pick_ibus;
  logic sel_rd;
  logic sel_wr;
  logic sel_req;
  logic grant;
  logic done;

  assign req_dbg  = dbg_avn_read  | dbg_avn_write;
  assign req_dbus = dbus_avn_read | dbus_avn_write;
  assign req_ibus = ibus_avn_read | ibus_avn_write;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic rr_ibus;
  assign pick_ibus = req_ibus & (~req_dbus | rr_ibus);
`else
  assign pick_ibus = req_ibus & ~req_dbus;
`endif

  always_comb begin
    win = OWN_NONE;
    unique case (1'b1)
      req_dbg:                         win = OWN_DBG;
      !req_dbg && pick_ibus:           win = OWN_IBUS;
      !req_dbg && !pick_ibus && req_dbus: win = OWN_DBUS;
      default:                         win = OWN_NONE;
    endcase
  end

  always_comb begin
    sel = OWN_DBUS;
    if (state == BUSY)
      sel = owner;
    else if (win != OWN_NONE)
      sel = win;
  end

  always_comb begin
    sel_rd              = dbus_avn_read;
    sel_wr              = dbus_avn_write;
    ram_avn_address     = dbus_avn_address;
    ram_avn_byte_enable = dbus_avn_byte_enable;
    ram_avn_writedata   = dbus_avn_writedata;
    unique case (sel)
      OWN_DBG: begin
        sel_rd              = dbg_avn_read;
        sel_wr              = dbg_avn_write;
        ram_avn_address     = dbg_avn_address;
        ram_avn_byte_enable = dbg_avn_byte_enable;
        ram_avn_writedata   = dbg_avn_writedata;
      end
      OWN_IBUS: begin
        sel_rd              = ibus_avn_read;
        sel_wr              = ibus_avn_write;
        ram_avn_address     = ibus_avn_address;
        ram_avn_byte_enable = ibus_avn_byte_enable;
        ram_avn_writedata   = ibus_avn_writedata;
      end
      default: ;
    endcase
  end

  // read+write together counts as a write; reset kills the strobe at once
  assign sel_req       = sel_rd | sel_wr;
  assign ram_avn_write = rst_n & sel_wr;
  assign ram_avn_read  = rst_n & sel_rd & ~sel_wr;

  assign grant = rst_n & sel_req;
  assign done  = grant & ~ram_avn_waitrequest;

  assign dbg_avn_waitrequest =
    ~(grant && sel == OWN_DBG) | ram_avn_waitrequest;
  assign dbus_avn_waitrequest =
    ~(grant && sel == OWN_DBUS) | ram_avn_waitrequest;
  assign ibus_avn_waitrequest =
    ~(grant && sel == OWN_IBUS) | ram_avn_waitrequest;

  assign dbg_avn_readdata  = ram_avn_readdata;
  assign dbus_avn_readdata = ram_avn_readdata;
  assign ibus_avn_readdata = ram_avn_readdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (win != OWN_NONE && ram_avn_waitrequest) begin
            owner <= win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!sel_req || !ram_avn_waitrequest) begin
            owner <= OWN_NONE;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ibus <= 1'b1;
    else if (done && sel == OWN_DBUS)
      rr_ibus <= 1'b1;
    else if (done && sel == OWN_IBUS)
      rr_ibus <= 1'b0;
  end
`endif

endmodule
